keyv_delay_loader: RTL and testbench
====================================

Name: keyv_delay_loader

Overview:
On-chip sequencer that replaces bench-driven scan-in of the keyring and mul/div delay lines. A host writes the flat delay configuration as 32-bit words into an internal buffer. On a start pulse, the block holds the core in reset, shifts the configuration serially into the delay scan chain, waits a reset-hold interval, and then releases the core. It sits in top, between the host/config port and the core's delay_en/delay_cfg and reset inputs.

Parameters:
DELAY_W, 8, bits per delay element
N_SLOTS, 39, delay elements in the chain (6 stages x 6 keyring slots + 3 mul/div)
NBITS, DELAY_W*N_SLOTS (312), scan chain length
NWORDS, ceil(NBITS/32) (10), buffer depth in 32-bit words
RST_HOLD, 5, cycles the core reset stays low after shifting ends

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rstn  in  1  asynchronous active-low reset
i_wr_valid  in  1  host word write request
i_wr_data  in  32  configuration word
o_wr_ready  out  1  buffer accepts writes (IDLE, RUN only)
i_start  in  1  single-cycle start of a configuration sequence
o_busy  out  1  high in SHIFT and HOLD
o_done  out  1  high in RUN (configured, core released)
o_delay_en  out  1  scan shift enable to the delay chain
o_delay_cfg  out  1  scan data to the delay chain
o_core_rstn  out  1  active-low reset to the core

Behaviour:
- Clock and reset: one clock; i_rstn is asynchronous and active-low.
- Values under reset: state=IDLE, wr_ptr=0, bit_cnt=0, hold_cnt=0, o_delay_en=0, o_delay_cfg=0, o_core_rstn=0, o_busy=0, o_done=0, o_wr_ready=1 (combinational from state). Buffer contents are don't-care.
- All outputs are registered except o_wr_ready.
- States: IDLE, SHIFT, HOLD, RUN.
- Write rule: a write is accepted when i_wr_valid & o_wr_ready.
  - buf[wr_ptr] <= i_wr_data.
  - wr_ptr increments and wraps from NWORDS-1 to 0.
  - Bits at flat index >= NBITS (buf[9][31:24] by default) are stored but never shifted.
- Flat bit k maps to buf[k/32][k%32].
- IDLE/RUN -> SHIFT when i_start=1. On the next edge:
  - o_core_rstn=0, o_done=0, o_busy=1, o_delay_en=1, o_delay_cfg=flat bit 0;
  - bit_cnt=0, wr_ptr=0.
- Write and start in the same cycle: the write commits first. SHIFT therefore uses the new word.
- SHIFT: each cycle bit_cnt increments and o_delay_cfg presents flat bit bit_cnt. Bits are shifted LSB-first, flat index ascending.
  - o_delay_en is high for exactly NBITS consecutive cycles.
  - After the cycle presenting bit NBITS-1, the next edge moves to HOLD: o_delay_en=0, o_delay_cfg=0, hold_cnt=0.
- HOLD: o_core_rstn stays 0 for RST_HOLD cycles.
  - When hold_cnt reaches RST_HOLD-1, the next edge moves to RUN: o_core_rstn=1, o_busy=0, o_done=1.
- RUN: outputs are stable. Writes are allowed and take effect only on the next i_start.
- i_start during SHIFT or HOLD is ignored; the sequence is not restarted.
- i_wr_valid during SHIFT or HOLD is not accepted (o_wr_ready=0) and the buffer is unchanged.
- i_start held high for more than one cycle: only the first cycle in IDLE/RUN acts. After RUN re-entry a still-high start triggers again; level-start is a host error.
- i_rstn asserted mid-sequence: all outputs return to reset values immediately and asynchronously.
  - o_core_rstn=0 and o_delay_en=0 at once, so the partially shifted chain is abandoned.
  - After reset release the state is IDLE; the host must restart.
- Total latency, from the start edge to o_core_rstn=1: 1 + NBITS + RST_HOLD edges (318 by default).

Test Plan:
1. Reset, write 10 words 0x0000_0000..0x0000_0009, pulse i_start -> o_delay_en high exactly 312 cycles; the serial stream equals the flat bits (word 1 bit 0 = 1 at cycle 32); o_core_rstn rises 5 cycles after o_delay_en falls; o_done=1.
2. Write 0xFFFF_FFFF to all words, start -> o_delay_cfg=1 for all 312 enabled cycles and 0 afterwards; bits 312..319 are never driven.
3. Pulse i_start and i_wr_valid during SHIFT at cycle 100 -> o_wr_ready=0, no restart, same 318-cycle total, buffer unchanged (verified by rerunning the shift from RUN).
4. From RUN, write word 0 = 0x0000_00A5 then start -> o_core_rstn drops on the next edge; the first 8 shifted bits are 1,0,1,0,0,1,0,1; the core is released again after 318 cycles.
5. Assert i_rstn low at SHIFT cycle 50 -> o_delay_en, o_core_rstn, o_busy go 0 without waiting for a clock edge; after release the state is IDLE with o_done=0 and wr_ptr=0.
6. Write 11 words (word 10 = 0xDEAD_BEEF) -> the pointer wraps and word 0 is overwritten; the shifted bits 0..31 equal 0xDEADBEEF LSB-first.

Source files
------------

// File: rtl/keyv_delay_loader.sv
// keyv_delay_loader: buffers host config words, scans them into the delay chain while holding the core in reset, then releases it.
module keyv_delay_loader #(
  parameter int DELAY_W  = 8,
  parameter int N_SLOTS  = 39,
  parameter int NBITS    = DELAY_W * N_SLOTS,
  parameter int NWORDS   = (NBITS + 31) / 32,
  parameter int RST_HOLD = 5
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_wr_valid,
  input  logic [31:0] i_wr_data,
  output logic        o_wr_ready,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_delay_en,
  output logic        o_delay_cfg,
  output logic        o_core_rstn
);
  localparam int PW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam int BW = $clog2(NBITS + 1);
  localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, RUN} state_t;
  state_t        r_state;
  logic [31:0]   r_buf [NWORDS];
  logic [PW-1:0] r_wr_ptr;
  logic [BW-1:0] r_bit_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          w_wr, w_bit0, w_nxt_bit, w_last, w_hold_last;
  logic [BW-1:0] w_nxt;
  logic [31:0]   w_nxt_word;
  assign o_wr_ready  = (r_state == IDLE) || (r_state == RUN);
  assign w_wr        = i_wr_valid & o_wr_ready;
  assign w_nxt       = r_bit_cnt + 1'b1;
  assign w_nxt_word  = r_buf[PW'(w_nxt >> 5)];
  assign w_nxt_bit   = w_nxt_word[w_nxt[4:0]];
  // A write landing in word 0 on the start cycle must be seen by the first shifted bit.
  assign w_bit0      = (w_wr && r_wr_ptr == '0) ? i_wr_data[0] : r_buf[0][0];
  assign w_last      = r_bit_cnt == BW'(NBITS - 1);
  assign w_hold_last = r_hold_cnt == HW'(RST_HOLD - 1);
  always_ff @(posedge i_clk)
    if (w_wr) r_buf[r_wr_ptr] <= i_wr_data;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_bit_cnt   <= '0;
      r_hold_cnt  <= '0;
      o_delay_en  <= 1'b0;
      o_delay_cfg <= 1'b0;
      o_core_rstn <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == PW'(NWORDS - 1)) ? '0 : r_wr_ptr + 1'b1;
      case (r_state)
        IDLE, RUN: if (i_start) begin
          r_state     <= SHIFT;
          o_core_rstn <= 1'b0;
          o_done      <= 1'b0;
          o_busy      <= 1'b1;
          o_delay_en  <= 1'b1;
          o_delay_cfg <= w_bit0;
          r_bit_cnt   <= '0;
          r_wr_ptr    <= '0;
        end
        SHIFT: if (w_last) begin
          r_state     <= HOLD;
          o_delay_en  <= 1'b0;
          o_delay_cfg <= 1'b0;
          r_hold_cnt  <= '0;
        end else begin
          r_bit_cnt   <= w_nxt;
          o_delay_cfg <= w_nxt_bit;
        end
        HOLD: if (w_hold_last) begin
          r_state     <= RUN;
          o_core_rstn <= 1'b1;
          o_busy      <= 1'b0;
          o_done      <= 1'b1;
        end else r_hold_cnt <= r_hold_cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_keyv_delay_loader.sv
// tb_keyv_delay_loader: randomized scenarios checked against a word-array model of the config buffer.
module tb_keyv_delay_loader;
  localparam int NBITS = 312;
  localparam int NWORDS = 10;
  localparam int LAT = 1 + NBITS + 5;
  logic i_clk = 0, i_rstn = 0, i_wr_valid = 0, i_start = 0;
  logic [31:0] i_wr_data = '0;
  logic o_wr_ready, o_busy, o_done, o_delay_en, o_delay_cfg, o_core_rstn;
  logic [31:0] mbuf [NWORDS];
  int mptr = 0, total = 0, bad = 0;
  keyv_delay_loader dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_delay_en(o_delay_en), .o_delay_cfg(o_delay_cfg), .o_core_rstn(o_core_rstn)
  );
  always #5 i_clk = ~i_clk;
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] d);
    i_wr_valid = 1;
    i_wr_data = d;
    mbuf[mptr] = d;
    mptr = (mptr + 1) % NWORDS;
    step();
    i_wr_valid = 0;
  endtask
  task automatic run_seq(input bit wr_with_start, input logic [31:0] wdata, input bit disturb,
                         output logic [NBITS-1:0] got);
    logic [NBITS-1:0] exp;
    int en_bad = 0, stray = 0, busy_err = 0, lat = 0;
    got = '0;
    i_start = 1;
    if (wr_with_start) begin
      i_wr_valid = 1;
      i_wr_data = wdata;
      mbuf[mptr] = wdata;
    end
    mptr = 0;
    for (int k = 0; k < NBITS; k++) exp[k] = mbuf[k / 32][k % 32];
    step();
    i_start = 0;
    i_wr_valid = 0;
    for (int t = 0; t < 400 && lat == 0; t++) begin
      if (o_delay_en !== (t < NBITS)) en_bad++;
      if (o_delay_en && t < NBITS) got[t] = o_delay_cfg;
      else if (o_delay_cfg !== 1'b0) stray++;
      if (o_core_rstn === 1'b1) lat = t + 1;
      else if (o_busy !== 1'b1 || o_done !== 1'b0 || o_wr_ready !== 1'b0) busy_err++;
      if (disturb && t == 100) begin
        total++;
        if (o_wr_ready !== 1'b0) begin bad++; $display("FAIL shift_wr_ready got=%b want=0", o_wr_ready); end
        i_start = 1;
        i_wr_valid = 1;
        i_wr_data = $urandom;
      end
      step();
      i_start = 0;
      i_wr_valid = 0;
    end
    total += 6;
    if (en_bad != 0) begin bad++; $display("FAIL en_window bad_cycles=%0d want=0", en_bad); end
    if (got !== exp) begin bad++; $display("FAIL stream got=%h want=%h", got, exp); end
    if (stray != 0) begin bad++; $display("FAIL cfg_idle stray=%0d want=0", stray); end
    if (lat != LAT) begin bad++; $display("FAIL latency got=%0d want=%0d", lat, LAT); end
    if (busy_err != 0) begin bad++; $display("FAIL busy_flags bad_cycles=%0d want=0", busy_err); end
    if ({o_done, o_busy, o_wr_ready, o_core_rstn} !== 4'b1011)
      begin bad++; $display("FAIL run_flags got=%b want=1011", {o_done, o_busy, o_wr_ready, o_core_rstn}); end
  endtask
  task automatic test_reset();
    #1;
    total++;
    if ({o_delay_en, o_delay_cfg, o_core_rstn, o_busy, o_done, o_wr_ready} !== 6'b000001)
      begin bad++; $display("FAIL reset got=%b want=000001", {o_delay_en, o_delay_cfg, o_core_rstn, o_busy, o_done, o_wr_ready}); end
    step();
    step();
    #2 i_rstn = 1;
    step();
  endtask
  task automatic test_counting();
    logic [NBITS-1:0] got;
    for (int i = 0; i < NWORDS; i++) wr(32'(i));
    run_seq(0, '0, 0, got);
    total++;
    if (got[32] !== 1'b1 || got[31:0] !== '0) begin bad++; $display("FAIL word1_bit0 got=%b want=1", got[32]); end
  endtask
  task automatic test_all_ones();
    logic [NBITS-1:0] got;
    for (int i = 0; i < NWORDS; i++) wr('1);
    run_seq(0, '0, 0, got);
    total++;
    if (got !== {NBITS{1'b1}}) begin bad++; $display("FAIL all_ones got=%h", got); end
  endtask
  task automatic test_shift_disturb();
    logic [NBITS-1:0] got;
    for (int i = 0; i < NWORDS; i++) wr($urandom);
    run_seq(0, '0, 1, got);
    run_seq(0, '0, 0, got);
  endtask
  task automatic test_restart_a5();
    logic [NBITS-1:0] got;
    wr(32'h0000_00A5);
    i_start = 1;
    mptr = 0;
    step();
    i_start = 0;
    total++;
    if (o_core_rstn !== 1'b0 || o_delay_cfg !== 1'b1)
      begin bad++; $display("FAIL restart_edge rstn=%b cfg=%b want 0,1", o_core_rstn, o_delay_cfg); end
    repeat (LAT + 2) step();
    run_seq(0, '0, 0, got);
    total++;
    if (got[7:0] !== 8'hA5) begin bad++; $display("FAIL a5_bits got=%h want=a5", got[7:0]); end
  endtask
  task automatic test_back_to_back();
    logic [NBITS-1:0] got;
    logic [31:0] w = $urandom;
    w[0] = ~mbuf[0][0];
    run_seq(1, w, 0, got);
    total++;
    if (got[31:0] !== w) begin bad++; $display("FAIL wr_with_start got=%h want=%h", got[31:0], w); end
  endtask
  task automatic test_async_reset();
    logic [NBITS-1:0] got;
    for (int i = 0; i < NWORDS; i++) wr($urandom);
    i_start = 1;
    step();
    i_start = 0;
    repeat (50) step();
    #2 i_rstn = 0;
    #1;
    total += 2;
    if ({o_delay_en, o_core_rstn, o_busy} !== 3'b000)
      begin bad++; $display("FAIL async_rst got=%b want=000", {o_delay_en, o_core_rstn, o_busy}); end
    if ({o_done, o_wr_ready} !== 2'b01) begin bad++; $display("FAIL async_flags got=%b want=01", {o_done, o_wr_ready}); end
    #13 i_rstn = 1;
    mptr = 0;
    step();
    total++;
    if ({o_done, o_wr_ready, o_delay_en} !== 3'b010)
      begin bad++; $display("FAIL post_rst got=%b want=010", {o_done, o_wr_ready, o_delay_en}); end
    for (int i = 0; i < NWORDS; i++) wr($urandom);
    run_seq(0, '0, 0, got);
  endtask
  task automatic test_wrap();
    logic [NBITS-1:0] got;
    for (int i = 0; i < NWORDS; i++) wr($urandom);
    wr(32'hDEAD_BEEF);
    run_seq(0, '0, 0, got);
    total++;
    if (got[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wrap got=%h want=deadbeef", got[31:0]); end
  endtask
  initial begin
    test_reset();
    test_counting();
    test_all_ones();
    test_shift_disturb();
    test_restart_a5();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
